// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - borrow_in, DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional macro SUB_SATURATE_EN clamps an underflowing result to zero at completion.
module digit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  res_reg;
    logic              borrow_reg;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              last;
    int                base;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dig_sum;
    logic [DIGIT-1:0]  d;
    logic              bout;
    logic [WIDTH-1:0]  res_next;
    logic [WIDTH-1:0]  final_diff;
    logic              final_zero;

    // Start is honoured in IDLE and in the single DONE cycle; a running operation is never disturbed.
    assign accept = start && (state != RUN);
    assign last   = (cnt == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One digit of the borrow chain; the sign bit of the (DIGIT+1)-bit difference is the new borrow.
    always_comb begin
        base     = int'(cnt) * DIGIT;
        a_dig    = a_reg[base +: DIGIT];
        b_dig    = b_reg[base +: DIGIT];
        dig_sum  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_reg};
        d        = dig_sum[DIGIT-1:0];
        bout     = dig_sum[DIGIT];
        res_next = res_reg;
        res_next[base +: DIGIT] = d;
    end

`ifdef SUB_SATURATE_EN
    always_comb begin
        final_diff = bout ? '0 : res_next;
        final_zero = bout ? 1'b1 : (res_next == '0);
    end
`else
    always_comb begin
        final_diff = res_next;
        final_zero = (res_next == '0);
    end
`endif

    // Operand capture, digit iteration and result publication; published outputs only change at completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            res_reg    <= '0;
            borrow_reg <= borrow_in;
            cnt        <= '0;
        end else if (state == RUN) begin
            res_reg    <= res_next;
            borrow_reg <= bout;
            cnt        <= cnt + 1'b1;
            if (last) begin
                diff       <= final_diff;
                borrow_out <= bout;
                zero       <= final_zero;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Scoreboard bench for digit_serial_subtractor (WIDTH=16, DIGIT=4); honours SUB_SATURATE_EN if defined.
module tb_digit_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    exp_t expq[$];
    int   testCount;
    int   failCount;
    int   lat;

    digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request at a negedge, push its expected result, then drop start at the next negedge.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic bin,
                                 input logic [15:0] ed, input logic eb, input logic ez);
        exp_t e;
        start     = 1'b1;
        a         = av;
        b         = bv;
        borrow_in = bin;
        e.diff = ed;
        e.bout = eb;
        e.zero = ez;
        expq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done, checking busy stays high meanwhile; bounded.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < 20) begin
            checkOutput("busy_during_run", {31'd0, busy}, 32'd1);
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_seen", {31'd0, done}, 32'd1);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("diff", {16'd0, diff}, {16'd0, e.diff});
                checkOutput("borrow_out", {31'd0, borrow_out}, {31'd0, e.bout});
                checkOutput("zero", {31'd0, zero}, {31'd0, e.zero});
            end
        end
    end

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_diff", {16'd0, diff}, 32'd0);
        checkOutput("reset_bout", {31'd0, borrow_out}, 32'd0);
        checkOutput("reset_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("latency", lat, 32'd4);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);

`ifdef SUB_SATURATE_EN
        applyStimulus(16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
`else
        applyStimulus(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
`endif
        waitDone(lat);
        @(negedge clk);

`ifdef SUB_SATURATE_EN
        applyStimulus(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1);
`else
        applyStimulus(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
`endif
        waitDone(lat);
        @(negedge clk);

        applyStimulus(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1);
        waitDone(lat);
        @(negedge clk);

        applyStimulus(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
        waitDone(lat);
        @(negedge clk);

        // A start pulse while busy must not disturb the running operation.
        applyStimulus(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        checkOutput("diff_held_while_busy", {16'd0, diff}, 32'h00FF);
        waitDone(lat);
        checkOutput("latency_ignored_start", lat, 32'd2);
        @(negedge clk);
        checkOutput("no_second_op", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a run: outputs clear at once and no done follows.
        start = 1'b1;
        a = 16'h1111;
        b = 16'h0001;
        borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_diff", {16'd0, diff}, 32'd0);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("no_done_after_abort", {31'd0, done}, 32'd0);

        applyStimulus(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("latency_after_reset", lat, 32'd4);
        @(negedge clk);

        // Back-to-back: start held through the DONE cycle with fresh operands.
        start = 1'b1;
        a = 16'h0010;
        b = 16'h0001;
        borrow_in = 1'b0;
        expq.push_back('{diff: 16'h000F, bout: 1'b0, zero: 1'b0});
        @(negedge clk);
        waitDone(lat);
        a = 16'hABCD;
        b = 16'h0BCD;
        expq.push_back('{diff: 16'hA000, bout: 1'b0, zero: 1'b0});
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_accepted", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b_spacing", lat, 32'd5);
        @(negedge clk);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/digit_serial_subtractor.md
Name: digit_serial_subtractor

Overview:
- Parametrised multi-cycle unsigned subtractor; computes A - B - borrow_in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle.
- Single registered borrow carries between digits.
- Successor to the 1-bit combinational half subtractor. Adds arbitrary width, a borrow input, a start/busy/done handshake, a zero flag and optional saturation.
- Used where a full-width borrow chain is too slow or too large.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH. Defines N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- borrow_in  input  1  initial borrow; captured on the accepting edge
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result; held stable until the next accepted start
- borrow_out  output  1  final borrow; 1 when a < b + borrow_in
- zero  output  1  1 when diff == 0; valid with diff

Behaviour:
- Reset (async assert, any time, including mid-operation): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, zero=0, internal operand/borrow/digit counter cleared. The aborted operation is lost; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - Capture a, b, borrow_in; counter=0; go to RUN.
  - busy=1 and done=0 from edge k.
  - diff/borrow_out/zero keep previous values until completion.
- RUN, each edge:
  - Digit i = counter: {bout, d} = a[i] - b[i] - borrow_reg, computed in DIGIT+1 bits; bout is the sign bit.
  - Write d into result slice i; borrow_reg <= bout; counter increments.
- Last digit (edge k+N):
  - diff <= full result; borrow_out <= final bout; zero <= (result == 0).
  - busy <= 0; done <= 1; go to DONE.
  - Latency is exactly N cycles from the accepting edge to done=1.
- DONE lasts one cycle: done=1 for exactly one cycle, then IDLE with done=0. start in the DONE cycle is accepted (back-to-back throughput of one result per N+1 cycles).
- start while busy=1 is ignored; the operands of the running operation are unaffected. No queueing.
- Input changes on a/b/borrow_in outside the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH (wrap-around). Example: 0 - 1 gives diff = all ones, borrow_out = 1.
- DIGIT = WIDTH (N=1): single RUN cycle; done one cycle after acceptance.
- Counter width is clog2(N), minimum 1 bit.

Optional Feature:
- SUB_SATURATE_EN defined:
  - When the final borrow is 1, diff is forced to 0 and zero=1 (unsigned floor saturation).
  - borrow_out still reports the raw borrow (1) so underflow remains visible.
  - Applied only at the completion edge; no added latency.
- SUB_SATURATE_EN undefined: wrap-around result as above; no saturation logic present.

Test Plan (WIDTH=16, DIGIT=4, N=4):
- Reset released; start=1, a=0x1234, b=0x0234, borrow_in=0 -> busy=1 for 4 cycles; done=1 on the 4th edge after acceptance; diff=0x1000, borrow_out=0, zero=0.
- a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, zero=0. With SUB_SATURATE_EN: diff=0x0000, borrow_out=1, zero=1.
- a=0x0005, b=0x0005, borrow_in=1 -> diff=0xFFFF, borrow_out=1. Repeat with borrow_in=0 -> diff=0x0000, zero=1, borrow_out=0. Digit-boundary borrow check: a=0x0100, b=0x0001 -> diff=0x00FF.
- Start op a=0x8000, b=0x0001; pulse start with a=0xFFFF, b=0xFFFF two cycles later -> second start ignored; diff=0x7FFF after 4 cycles; busy never drops early.
- Start op, assert rst asynchronously (mid-clock) after 2 RUN cycles -> all outputs 0 immediately, no done pulse. After release, new op a=0x00FF, b=0x000F -> diff=0x00F0, done after 4 cycles.
- Back-to-back: start held high through the DONE cycle with new operands a=0xABCD, b=0x0BCD -> second op accepted in the DONE cycle; diff=0xA000 exactly 5 cycles after the first done.
